axistream_write_fifo: RTL
=========================

// Module: axistream_write_fifo
// PURPOSE
//  Parametrised AXI4-Stream write master, successor to the single-beat stream writer.
//  Accepts a programmed-length transfer of words from a local producer over valid/ready.
//  Buffers the words in a DEPTH-entry FIFO and drives them onto the ss_* stream toward the FIR.
//  Generates ss_tlast on the final beat and a done pulse when the transfer completes.
// PARAMETERS
//  pDATA_WIDTH  32  data word width (ss_tdata, in_data)
//  pFIFO_DEPTH  8   FIFO entries; power of two, >= 2
//  pLEN_WIDTH   12  width of transfer-length field / beat counters
// PORTS
//  axis_clk    in   1             single clock; all logic on posedge
//  axis_rst    in   1             synchronous, active-high reset
//  cfg_start   in   1             1-cycle pulse: begin transfer of cfg_len words
//  cfg_len     in   pLEN_WIDTH    transfer length in words; sampled only with cfg_start in IDLE
//  busy        out  1             high from accepted start until done
//  done        out  1             1-cycle pulse after last beat handshakes
//  in_valid    in   1             producer word valid
//  in_data     in   pDATA_WIDTH   producer word
//  in_ready    out  1             block can accept in_data this cycle
//  ss_tvalid   out  1             stream beat valid
//  ss_tdata    out  pDATA_WIDTH   stream beat data
//  ss_tlast    out  1             final beat of transfer
//  ss_tready   in   1             downstream (FIR) ready
//  fifo_count  out  $clog2(pFIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (axis_rst=1 at posedge): state=IDLE; FIFO pointers, count, in_cnt, out_cnt cleared;
//   busy=0, done=0, in_ready=0, ss_tvalid=0, ss_tlast=0, ss_tdata=0, fifo_count=0.
//   Reset mid-transfer discards buffered words; no further beats; no done pulse.
//  FSM: IDLE -> STREAM on cfg_start with cfg_len!=0 (latch len). IDLE -> DONE on cfg_start
//   with cfg_len==0 (no beats). STREAM -> DONE on handshake of beat len-1. DONE -> IDLE
//   unconditionally; done=1 only in DONE; busy=1 in STREAM and DONE.
//  cfg_start outside IDLE is ignored; cfg_len changes after start have no effect.
//  Input side: in_ready = (state==STREAM) && !full && (in_cnt < len); registered-state based,
//   does not depend on same-cycle pop. Push on in_valid&&in_ready; in_cnt increments.
//  Output side: ss_tvalid = (state==STREAM) && !empty; ss_tdata = FIFO head;
//   ss_tlast = ss_tvalid && (out_cnt == len-1). Pop and out_cnt++ on ss_tvalid&&ss_tready.
//  AXIS rule: once ss_tvalid=1 it holds, with ss_tdata/ss_tlast stable, until ss_tready=1.
//  Latency: word pushed at edge N is visible on ss_tdata/ss_tvalid after edge N (cycle N+1)
//   when FIFO was empty; no combinational path in_data -> ss_tdata.
//  Simultaneous push and pop: allowed when not full; count unchanged; pointers both advance.
//  Full: in_ready=0 until a pop has registered. Empty: ss_tvalid=0.
//  Pointers wrap modulo pFIFO_DEPTH; count range 0..pFIFO_DEPTH inclusive.
//  Counters are pLEN_WIDTH bits; max transfer 2**pLEN_WIDTH-1 words; no wrap within a transfer.
//  Words offered after in_cnt reaches len are not accepted (in_ready=0).
// TESTING
//  1. cfg_len=4, data 1..4, ss_tready=1 -> 4 beats 1,2,3,4; tlast only on 4; done 1 cycle
//     after beat 4; busy 0 next cycle.
//  2. cfg_len=20, ss_tready=0 for 30 cycles -> fifo_count saturates at 8, in_ready=0, tvalid
//     held with data 1 stable; release tready -> all 20 in order, tlast on 20th.
//  3. cfg_len=0 -> done pulses on cycle after start; ss_tvalid never asserts.
//  4. Random in_valid/ss_tready toggling, cfg_len=100 -> output sequence equals input, no
//     duplicate/drop; count never exceeds 8; tvalid never drops without handshake.
//  5. axis_rst asserted after 5 of 10 beats -> all outputs 0 next cycle, fifo_count=0, no done;
//     new start cfg_len=3 then completes normally.
//  6. cfg_start pulsed during STREAM with different cfg_len -> ignored; original length honoured.

Source files
------------

// File: rtl/axistream_write_fifo_if.sv
// Word-in / AXI4-Stream-out handshake bundle for the stream write FIFO.
// The 'master' view belongs to the block driving the ss_* stream; 'slave' is its environment.
`timescale 1ns/1ps
interface axistream_write_fifo_if #(
   parameter int pDATA_WIDTH = 32
);
   logic                   in_valid;
   logic [pDATA_WIDTH-1:0] in_data;
   logic                   in_ready;
   logic                   ss_tvalid;
   logic [pDATA_WIDTH-1:0] ss_tdata;
   logic                   ss_tlast;
   logic                   ss_tready;

   modport master (
      input  in_valid, in_data, ss_tready,
      output in_ready, ss_tvalid, ss_tdata, ss_tlast
   );

   modport slave (
      output in_valid, in_data, ss_tready,
      input  in_ready, ss_tvalid, ss_tdata, ss_tlast
   );
endinterface

// File: rtl/axistream_write_fifo.sv
// Buffers a programmed-length word transfer in a DEPTH-entry FIFO and streams it out with tlast/done;
// one cycle push-to-beat latency, in_ready drops on full or once len words are accepted.
`timescale 1ns/1ps
module axistream_write_fifo #(
   parameter int pDATA_WIDTH = 32,
   parameter int pFIFO_DEPTH = 8,
   parameter int pLEN_WIDTH  = 12
) (
   input  logic                           axis_clk,
   input  logic                           axis_rst,
   input  logic                           cfg_start,
   input  logic [pLEN_WIDTH-1:0]          cfg_len,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(pFIFO_DEPTH):0]   fifo_count,
   axistream_write_fifo_if.master         bus
);

   localparam int AW = $clog2(pFIFO_DEPTH);
   localparam logic [AW:0]           DEPTH_CNT = pFIFO_DEPTH[AW:0];
   localparam logic [AW:0]           CNT_ONE   = 1;
   localparam logic [AW-1:0]         PTR_ONE   = 1;
   localparam logic [pLEN_WIDTH-1:0] LEN_ONE   = 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [pLEN_WIDTH-1:0]   len_q;
   logic [pLEN_WIDTH-1:0]   in_cnt_q;
   logic [pLEN_WIDTH-1:0]   out_cnt_q;
   logic [AW-1:0]           wr_ptr_q;
   logic [AW-1:0]           rd_ptr_q;
   logic [AW:0]             count_q;
   logic [pDATA_WIDTH-1:0]  mem [pFIFO_DEPTH];

   logic full, empty, push, pop, last_beat, start_ok;

   assign full       = (count_q == DEPTH_CNT);
   assign empty      = (count_q == '0);
   assign last_beat  = (out_cnt_q == (len_q - LEN_ONE));
   assign start_ok   = (state_q == S_IDLE) && cfg_start;
   assign fifo_count = count_q;

   // Both sides look only at registered state, so in_ready never waits on a same-cycle pop.
   assign bus.in_ready  = (state_q == S_STREAM) && !full && (in_cnt_q < len_q);
   assign bus.ss_tvalid = (state_q == S_STREAM) && !empty;
   assign bus.ss_tlast  = bus.ss_tvalid && last_beat;
   assign bus.ss_tdata  = bus.ss_tvalid ? mem[rd_ptr_q] : '0;

   assign push = bus.in_valid  && bus.in_ready;
   assign pop  = bus.ss_tvalid && bus.ss_tready;

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               state_d = (cfg_len == '0) ? S_DONE : S_STREAM;
            end
         end
         S_STREAM: begin
            busy = 1'b1;
            if (pop && last_beat) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else if (start_ok) begin
         len_q     <= cfg_len;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
      end else begin
         if (push) in_cnt_q  <= in_cnt_q + LEN_ONE;
         if (pop)  out_cnt_q <= out_cnt_q + LEN_ONE;
      end
   end

   // Pointer width equals log2(depth), so natural overflow gives the modulo wrap.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge axis_clk) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.in_data;
      end
   end

   a_tvalid_hold: assert property (@(posedge axis_clk) disable iff (axis_rst)
      (bus.ss_tvalid && !bus.ss_tready) |=> (bus.ss_tvalid && $stable(bus.ss_tdata) && $stable(bus.ss_tlast)));

   a_count_range: assert property (@(posedge axis_clk) disable iff (axis_rst)
      count_q <= DEPTH_CNT);

endmodule
